game_input_spawner: RTL and testbench
=====================================

GAME_INPUT_SPAWNER -- requirements
Module: game_input_spawner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000: cycles a raw button level must stay stable to be accepted.
REQ-002 SHALL have parameter SPAWN_PERIOD, default 50000000: cycles between object spawns.
REQ-003 SHALL have parameter FIRE_COOLDOWN, default 12500000: minimum cycles between two bullet pulses.
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1: nonzero LFSR reset value.
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port btn_left, input, 1: raw, asynchronous, active-high button.
REQ-008 SHALL have port btn_right, input, 1: raw, asynchronous, active-high button.
REQ-009 SHALL have port btn_fire, input, 1: raw, asynchronous, active-high button.
REQ-010 SHALL have port object_position, output, 11: spawn x-coordinate; 1000 means no object.
REQ-011 SHALL have port move, output, 2: 0 means right step, 1 means left step, 3 means idle.
REQ-012 SHALL have port bullet, output, 1: one-cycle fire request.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Each synchronized button SHALL have its own debouncer: counter clears on any level change and increments while the level holds; debounced state takes the new level when the count reaches DEBOUNCE_CYCLES-1.
REQ-015 move SHALL be 0 for exactly one cycle on a debounced btn_right rising edge, 1 for one cycle on a debounced btn_left rising edge, and 3 otherwise.
REQ-016 If both rising edges fall in the same cycle, or the opposite button is debounced-high, move SHALL stay 3.
REQ-017 move SHALL never show 0 or 1 for two consecutive cycles, because every cycle of 0 or 1 moves the plane downstream.
REQ-018 bullet SHALL pulse high for one cycle on a debounced btn_fire rising edge only when the cooldown counter is 0; the pulse loads the counter with FIRE_COOLDOWN-1, and the counter decrements to 0 and saturates there.
REQ-019 A fire edge during cooldown SHALL be dropped, not queued.
REQ-020 The 16-bit Fibonacci LFSR SHALL use taps 16,14,13,11 and advance every cycle.
REQ-021 Spawn counter SHALL count 0..SPAWN_PERIOD-1 and wrap; at the wrap cycle, object_position SHALL equal {2'b0, lfsr[8:0]} + 40 (range 40..551) for exactly one cycle.
REQ-022 Outside the spawn cycle, object_position SHALL be 1000.
REQ-023 All outputs SHALL be registered, with one cycle of latency from the internal event to the output.
REQ-024 A spawn, a move and a bullet in the same cycle SHALL all be emitted; they are independent.

Reset
REQ-025 While reset is low: object_position=1000, move=3, bullet=0, LFSR=LFSR_SEED, and all counters, synchronizer flops and debounced states = 0.
REQ-026 Reset assertion mid-debounce or mid-cooldown SHALL abort the operation; a button held through deassertion SHALL yield one edge after DEBOUNCE_CYCLES.
REQ-027 The first spawn SHALL occur SPAWN_PERIOD cycles after reset deassertion.

Structure
REQ-028 A shared package SHALL hold UNDEFINED_POSITION=1000, MOVE_RIGHT=0, MOVE_LEFT=1, MOVE_IDLE=3, SPAWN_X_OFFSET=40 and OBJECT_WIDTH=50; the downstream VGA stage SHALL use the same package.
REQ-029 Sub-module button_debounce (synchronizer, debouncer and rising-edge output) SHALL be instantiated three times.

Verification (DEBOUNCE_CYCLES=4, SPAWN_PERIOD=32, FIRE_COOLDOWN=8)
REQ-030 Hold btn_right high for 20 cycles -> exactly one cycle of move=0, about 7 cycles after the press, then move=3.
REQ-031 Toggle btn_left every 2 cycles, then hold it high -> no move=1 during bounce; one move=1 after it settles.
REQ-032 Press fire at t, t+3 and t+12 (each debounced) -> bullet at the first and third presses only.
REQ-033 Run 100 cycles after reset -> object_position not 1000 only on cycles 32, 64 and 96 (plus latency), with every value in 40..551.
REQ-034 Press left and right together -> move stays 3.
REQ-035 Assert reset for 1 cycle during cooldown with fire held -> outputs at reset values; one bullet after debounce.

Source files
------------

// File: rtl/game_input_spawner_pkg.sv
// Shared constants and helpers for the input/spawner block and the downstream VGA stage.
package game_input_spawner_pkg;

    localparam int POS_W = 11;

    localparam logic [POS_W-1:0] UNDEFINED_POSITION = 11'd1000;
    localparam logic [POS_W-1:0] SPAWN_X_OFFSET     = 11'd40;
    localparam int               OBJECT_WIDTH       = 50;

    typedef enum logic [1:0] {
        MOVE_RIGHT = 2'd0,
        MOVE_LEFT  = 2'd1,
        MOVE_IDLE  = 2'd3
    } move_t;

    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_FIRE  = 2;
    localparam int NUM_BTNS  = 3;

    // Fibonacci LFSR, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

    function automatic logic [POS_W-1:0] spawn_x(input logic [8:0] rnd);
        return {2'b00, rnd} + SPAWN_X_OFFSET;
    endfunction

endpackage

// File: rtl/game_input_spawner_button_debounce.sv
// Two-flop synchronizer, stability-counter debouncer and rising-edge strobe for one raw button.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic rise
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          last_reg;
    logic          state_reg;
    logic [CW-1:0] cnt_reg;
    logic          stable;
    logic          accept;

    assign stable = (sync2_reg == last_reg);
    assign accept = stable && (cnt_reg == CNT_MAX) && (last_reg != state_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            last_reg  <= 1'b0;
            state_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            last_reg  <= sync2_reg;
            if (!stable)
                cnt_reg <= '0;
            else if (cnt_reg != CNT_MAX)
                cnt_reg <= cnt_reg + CW'(1);
            if (accept)
                state_reg <= last_reg;
        end
    end

    // Strobe fires in the cycle the new high level is accepted, one cycle ahead of level.
    assign level = state_reg;
    assign rise  = accept && last_reg;

endmodule

// File: rtl/game_input_spawner.sv
// Debounced move/fire requests with fire cooldown, plus periodic pseudo-random object spawns.
module game_input_spawner
    import game_input_spawner_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          SPAWN_PERIOD    = 50000000,
    parameter int          FIRE_COOLDOWN   = 12500000,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_fire,
    output logic [POS_W-1:0] object_position,
    output logic [1:0]       move,
    output logic             bullet
);
    localparam int SCW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam int FCW = (FIRE_COOLDOWN > 1) ? $clog2(FIRE_COOLDOWN) : 1;
    localparam logic [SCW-1:0] SPAWN_MAX = SCW'(SPAWN_PERIOD - 1);
    localparam logic [FCW-1:0] COOL_MAX  = FCW'(FIRE_COOLDOWN - 1);

    logic [NUM_BTNS-1:0] btn_vec;
    logic [NUM_BTNS-1:0] level_vec;
    logic [NUM_BTNS-1:0] rise_vec;

    assign btn_vec[BTN_RIGHT] = btn_right;
    assign btn_vec[BTN_LEFT]  = btn_left;
    assign btn_vec[BTN_FIRE]  = btn_fire;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk  (clk),
                .reset(reset),
                .btn  (btn_vec[gi]),
                .level(level_vec[gi]),
                .rise (rise_vec[gi])
            );
        end
    endgenerate

    move_t            move_reg;
    move_t            move_next;
    logic             bullet_reg;
    logic             fire_ok;
    logic [FCW-1:0]   cool_reg;
    logic [SCW-1:0]   spawn_cnt_reg;
    logic             spawn_wrap;
    logic [15:0]      lfsr_reg;
    logic [POS_W-1:0] position_reg;

    // A move is a one-shot step; simultaneous or conflicting presses, and back-to-back steps, are suppressed.
    always_comb begin
        move_next = MOVE_IDLE;
        if (move_reg == MOVE_IDLE) begin
            if (rise_vec[BTN_RIGHT] && !rise_vec[BTN_LEFT] && !level_vec[BTN_LEFT])
                move_next = MOVE_RIGHT;
            else if (rise_vec[BTN_LEFT] && !rise_vec[BTN_RIGHT] && !level_vec[BTN_RIGHT])
                move_next = MOVE_LEFT;
        end
    end

    assign fire_ok    = rise_vec[BTN_FIRE] && (cool_reg == '0);
    assign spawn_wrap = (spawn_cnt_reg == SPAWN_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            move_reg      <= MOVE_IDLE;
            bullet_reg    <= 1'b0;
            cool_reg      <= '0;
            spawn_cnt_reg <= '0;
            lfsr_reg      <= LFSR_SEED;
            position_reg  <= UNDEFINED_POSITION;
        end else begin
            move_reg   <= move_next;
            bullet_reg <= fire_ok;
            if (fire_ok)
                cool_reg <= COOL_MAX;
            else if (cool_reg != '0)
                cool_reg <= cool_reg - FCW'(1);
            spawn_cnt_reg <= spawn_wrap ? '0 : spawn_cnt_reg + SCW'(1);
            lfsr_reg      <= lfsr_next(lfsr_reg);
            position_reg  <= spawn_wrap ? spawn_x(lfsr_reg[8:0]) : UNDEFINED_POSITION;
        end
    end

    assign object_position = position_reg;
    assign move            = move_reg;
    assign bullet          = bullet_reg;

endmodule

// File: tb/tb_game_input_spawner.sv
// Directed bench for game_input_spawner: moves, debounce, fire cooldown, spawns and reset abort.
module tb_game_input_spawner;
    localparam int          DB   = 4;
    localparam int          SP   = 32;
    // Cooldown long enough that a fully debounced re-press can land inside it.
    localparam int          FC   = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_fire = 1'b0;
    logic [10:0] object_position;
    logic [1:0]  move;
    logic        bullet;

    always #5 clk = ~clk;

    game_input_spawner #(
        .DEBOUNCE_CYCLES(DB),
        .SPAWN_PERIOD   (SP),
        .FIRE_COOLDOWN  (FC),
        .LFSR_SEED      (SEED)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_left       (btn_left),
        .btn_right      (btn_right),
        .btn_fire       (btn_fire),
        .object_position(object_position),
        .move           (move),
        .bullet         (bullet)
    );

    int checks = 0;
    int failures = 0;

    logic [15:0] m_lfsr = SEED;
    int          m_cnt = 0;
    int          t = 0;
    int          n_right = 0;
    int          n_left = 0;
    int          n_bullet = 0;
    int          n_spawn = 0;
    int          right_at = -1;
    int          left_at = -1;
    int          first_spawn = -1;
    int          bullet_at[$];
    logic [1:0]  prev_move = 2'd3;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic clear_stats();
        t = 0;
        n_right = 0;
        n_left = 0;
        n_bullet = 0;
        n_spawn = 0;
        right_at = -1;
        left_at = -1;
        first_spawn = -1;
        bullet_at.delete();
    endtask

    task automatic tick();
        int exp_pos;
        @(posedge clk);
        if (!reset) begin
            exp_pos = 1000;
        end else begin
            exp_pos = (m_cnt == SP - 1) ? (int'(m_lfsr[8:0]) + 40) : 1000;
            m_lfsr = lfsr_step(m_lfsr);
            m_cnt = (m_cnt == SP - 1) ? 0 : m_cnt + 1;
        end
        #1;
        t++;
        check_eq("object_position", int'(object_position), exp_pos);
        if (object_position != 11'd1000) begin
            n_spawn++;
            if (first_spawn < 0) first_spawn = t;
            check_eq("spawn_range", int'(object_position >= 11'd40 && object_position <= 11'd551), 1);
        end
        if (move != 2'd3) check_eq("move_gap", int'(prev_move), 3);
        if (move == 2'd2) check_eq("move_code", int'(move), 3);
        if (move == 2'd0) begin n_right++; right_at = t; end
        if (move == 2'd1) begin n_left++; left_at = t; end
        if (bullet) begin n_bullet++; bullet_at.push_back(t); end
        prev_move = move;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int b0;
        int b1;

        // reset state
        ticks(2);
        check_eq("rst_position", int'(object_position), 1000);
        check_eq("rst_move", int'(move), 3);
        check_eq("rst_bullet", int'(bullet), 0);
        reset = 1'b1;
        m_lfsr = SEED;
        m_cnt = 0;

        // spawn timing over 100 cycles
        clear_stats();
        ticks(100);
        check_eq("spawn_count", n_spawn, 3);
        check_eq("spawn_first", first_spawn, 32);
        check_eq("idle_moves", n_right + n_left, 0);
        check_eq("idle_bullets", n_bullet, 0);
        $display("spawn run: spawns=%0d first=%0d", n_spawn, first_spawn);

        // right held 20 cycles
        clear_stats();
        btn_right = 1'b1;
        ticks(20);
        check_eq("right_count", n_right, 1);
        check_eq("right_time", right_at, 7);
        check_eq("right_no_left", n_left, 0);
        btn_right = 1'b0;
        ticks(12);
        check_eq("right_release", n_right, 1);
        $display("right hold: moves=%0d at=%0d", n_right, right_at);

        // left bouncing then settling
        clear_stats();
        for (int i = 0; i < 3; i++) begin
            btn_left = 1'b1;
            ticks(2);
            btn_left = 1'b0;
            ticks(2);
        end
        check_eq("bounce_no_left", n_left, 0);
        clear_stats();
        btn_left = 1'b1;
        ticks(12);
        check_eq("settle_left_count", n_left, 1);
        check_eq("settle_left_time", left_at, 7);
        btn_left = 1'b0;
        ticks(12);
        $display("left bounce: moves=%0d at=%0d", n_left, left_at);

        // both pressed together
        clear_stats();
        btn_left = 1'b1;
        btn_right = 1'b1;
        ticks(12);
        check_eq("both_left", n_left, 0);
        check_eq("both_right", n_right, 0);
        btn_left = 1'b0;
        btn_right = 1'b0;
        ticks(12);
        $display("both pressed: left=%0d right=%0d", n_left, n_right);

        // right pressed while left already held
        clear_stats();
        btn_left = 1'b1;
        ticks(10);
        btn_right = 1'b1;
        ticks(10);
        check_eq("held_left_count", n_left, 1);
        check_eq("held_right_blocked", n_right, 0);
        btn_left = 1'b0;
        btn_right = 1'b0;
        ticks(12);
        $display("opposite held: left=%0d right=%0d", n_left, n_right);

        // three debounced fire presses, second inside cooldown
        clear_stats();
        for (int i = 0; i < 3; i++) begin
            btn_fire = 1'b1;
            ticks(6);
            btn_fire = 1'b0;
            ticks(6);
        end
        ticks(12);
        b0 = (bullet_at.size() > 0) ? bullet_at[0] : -1;
        b1 = (bullet_at.size() > 1) ? bullet_at[1] : -1;
        check_eq("fire_count", n_bullet, 2);
        check_eq("fire_first", b0, 7);
        check_eq("fire_third", b1, 31);
        $display("fire presses: bullets=%0d at=%0d,%0d", n_bullet, b0, b1);

        // reset during cooldown with fire held
        clear_stats();
        btn_fire = 1'b1;
        ticks(7);
        check_eq("pre_reset_bullet", int'(bullet), 1);
        reset = 1'b0;
        #1;
        check_eq("async_rst_bullet", int'(bullet), 0);
        check_eq("async_rst_move", int'(move), 3);
        check_eq("async_rst_position", int'(object_position), 1000);
        m_lfsr = SEED;
        m_cnt = 0;
        tick();
        reset = 1'b1;
        clear_stats();
        ticks(12);
        b0 = (bullet_at.size() > 0) ? bullet_at[0] : -1;
        check_eq("post_reset_bullets", n_bullet, 1);
        check_eq("post_reset_time", b0, 7);
        btn_fire = 1'b0;
        ticks(40);
        check_eq("post_reset_spawn", first_spawn, 32);
        $display("reset in cooldown: bullets=%0d at=%0d spawn=%0d", n_bullet, b0, first_spawn);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
